// File: rtl/dm_store_buffer.sv
// dm_store_buffer
//
// Store buffer between the execute stage and the 16-word data memory. Word stores are
// queued in a circular FIFO. They drain one per cycle into the memory write port, and a
// load on the port takes priority over a drain. Loads that hit a pending word (bits
// [5:2]) get the youngest buffered data. A fence request drains the whole buffer and
// then pulses o_fence_done.
//
// Ports
//   i_clk, i_reset    posedge clock; synchronous active-high reset
//   i_st_valid/addr/data, o_st_ready
//                     store request; accepted when valid && ready
//   i_ld_valid        a load occupies the memory port this cycle
//   i_ld_addr         load byte address
//   o_ld_hit/o_ld_data
//                     combinational forwarding result (data is 0 on a miss)
//   i_fence_req       level request to drain the buffer completely
//   o_fence_done      one-cycle pulse when the drain completes
//   o_dm_wr_en/o_dm_addr/o_dm_data
//                     registered memory write port (the memory writes on negedge)
//   o_count           number of queued entries, not counting the issued one
module dm_store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 32
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_st_valid,
   input  logic [AW-1:0]            i_st_addr,
   input  logic [DW-1:0]            i_st_data,
   output logic                     o_st_ready,
   input  logic                     i_ld_valid,
   input  logic [AW-1:0]            i_ld_addr,
   output logic                     o_ld_hit,
   output logic [DW-1:0]            o_ld_data,
   input  logic                     i_fence_req,
   output logic                     o_fence_done,
   output logic                     o_dm_wr_en,
   output logic [AW-1:0]            o_dm_addr,
   output logic [DW-1:0]            o_dm_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {StIdle, StFence, StDone} state_t;

   state_t        r_state;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   logic          r_wr_en;
   logic [AW-1:0] r_dm_addr;
   logic [DW-1:0] r_dm_data;
   logic          r_fence_done;

   logic          w_enq;
   logic          w_issue;
   logic          w_can_issue;
   logic [PW-1:0] w_idx;
   logic          w_unused;

   // Only the word index takes part in matching.
   assign w_unused = ^{i_ld_addr[AW-1:6], i_ld_addr[1:0]};

   // A full buffer refuses a store even when an issue frees a slot at the same edge.
   assign o_st_ready = (r_count != CW'(DEPTH)) && (r_state == StIdle);
   assign w_enq      = i_st_valid && o_st_ready;

   always_comb begin
      w_can_issue = 1'b0;
      case (r_state)
         StIdle:  w_can_issue = !i_ld_valid;
         StFence: w_can_issue = 1'b1;
         default: w_can_issue = 1'b0;
      endcase
   end

   assign w_issue = (r_count != '0) && w_can_issue;

   // Queue storage: the entry contents need no reset, because r_count sets validity.
   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         r_addr[r_tail] <= i_st_addr;
         r_data[r_tail] <= i_st_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_dm_addr <= '0;
         r_dm_data <= '0;
      end else begin
         if (w_enq) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_issue) begin
            r_head    <= r_head + PW'(1);
            r_wr_en   <= 1'b1;
            r_dm_addr <= r_addr[r_head];
            r_dm_data <= r_data[r_head];
         end else begin
            r_wr_en <= 1'b0;
         end
         case ({w_enq, w_issue})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Fence control. In StFence, r_count == 0 already means that no issue happens at
   // this edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_fence_done <= 1'b0;
      end else begin
         r_fence_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_fence_req) begin
                  r_state <= StFence;
               end
            end
            StFence: begin
               if (r_count == '0) begin
                  r_state      <= StDone;
                  r_fence_done <= 1'b1;
               end
            end
            StDone:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   // Forwarding. The issued register has the lowest priority: the memory commits it only
   // at the coming negedge. Queue entries are then scanned from oldest to youngest, so
   // the youngest match is the one that ends up in the output.
   always_comb begin
      o_ld_hit  = 1'b0;
      o_ld_data = '0;
      w_idx     = '0;
      if (r_wr_en && (r_dm_addr[5:2] == i_ld_addr[5:2])) begin
         o_ld_hit  = 1'b1;
         o_ld_data = r_dm_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PW'(i);
         if ((CW'(i) < r_count) && (r_addr[w_idx][5:2] == i_ld_addr[5:2])) begin
            o_ld_hit  = 1'b1;
            o_ld_data = r_data[w_idx];
         end
      end
   end

   assign o_fence_done = r_fence_done;
   assign o_dm_wr_en   = r_wr_en;
   assign o_dm_addr    = r_dm_addr;
   assign o_dm_data    = r_dm_data;
   assign o_count      = r_count;

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        fence_req;
   logic        fence_done;
   logic        dm_wr_en;
   logic [31:0] dm_addr;
   logic [31:0] dm_data;
   logic [2:0]  count;

   always #5 clk = ~clk;

   dm_store_buffer #(
      .DEPTH(DEPTH),
      .DW   (32),
      .AW   (32)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_st_valid  (st_valid),
      .i_st_addr   (st_addr),
      .i_st_data   (st_data),
      .o_st_ready  (st_ready),
      .i_ld_valid  (ld_valid),
      .i_ld_addr   (ld_addr),
      .o_ld_hit    (ld_hit),
      .o_ld_data   (ld_data),
      .i_fence_req (fence_req),
      .o_fence_done(fence_done),
      .o_dm_wr_en  (dm_wr_en),
      .o_dm_addr   (dm_addr),
      .o_dm_data   (dm_data),
      .o_count     (count)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   // Reference model: a plain queue of pending stores plus the word that was issued last.
   entry_t      mq[$];
   logic        m_wr;
   logic [31:0] m_addr;
   logic [31:0] m_data;
   int          m_mode;   // 0 idle, 1 fence, 2 done
   logic        m_done;

   entry_t      wr_log[$];
   int          done_pulses;
   logic        last_ready;
   logic        last_hit;
   logic [31:0] last_ldata;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
      return a[5:2] == b[5:2];
   endfunction

   // One clock cycle. It starts at a negedge, checks the combinational outputs before the
   // edge and the registered outputs #1 after it, and ends at the next negedge.
   task automatic cycle(input logic rst, input logic sv, input logic [31:0] sa,
                        input logic [31:0] sd, input logic lv, input logic [31:0] la,
                        input logic fr);
      logic        exp_ready;
      logic        exp_hit;
      logic [31:0] exp_ld;
      bit          issue;
      bit          enq;
      int          sz;
      entry_t      e;
      reset = rst; st_valid = sv; st_addr = sa; st_data = sd;
      ld_valid = lv; ld_addr = la; fence_req = fr;
      #1;
      exp_ready = (mq.size() < DEPTH) && (m_mode == 0);
      exp_hit   = 1'b0;
      exp_ld    = '0;
      if (m_wr && same_word(m_addr, la)) begin
         exp_hit = 1'b1;
         exp_ld  = m_data;
      end
      foreach (mq[i]) begin
         if (same_word(mq[i].addr, la)) begin
            exp_hit = 1'b1;
            exp_ld  = mq[i].data;
         end
      end
      last_ready = st_ready;
      last_hit   = ld_hit;
      last_ldata = ld_data;
      check_eq("st_ready", st_ready, exp_ready);
      check_eq("ld_hit", ld_hit, exp_hit);
      check_eq("ld_data", ld_data, exp_ld);

      if (rst) begin
         mq.delete();
         m_wr = 0; m_addr = '0; m_data = '0; m_mode = 0; m_done = 0;
      end else begin
         sz     = mq.size();
         issue  = (sz > 0) && (m_mode == 1 || (m_mode == 0 && !lv));
         enq    = sv && exp_ready;
         m_done = (m_mode == 1) && (sz == 0);
         case (m_mode)
            0:       if (fr) m_mode = 1;
            1:       if (sz == 0) m_mode = 2;
            default: m_mode = 0;
         endcase
         if (issue) begin
            e      = mq.pop_front();
            m_wr   = 1;
            m_addr = e.addr;
            m_data = e.data;
         end else begin
            m_wr = 0;
         end
         if (enq) begin
            e.addr = sa;
            e.data = sd;
            mq.push_back(e);
         end
      end

      @(posedge clk);
      #1;
      check_eq("dm_wr_en", dm_wr_en, m_wr);
      check_eq("dm_addr", dm_addr, m_addr);
      check_eq("dm_data", dm_data, m_data);
      check_eq("count", count, mq.size());
      check_eq("fence_done", fence_done, m_done);
      if (dm_wr_en) begin
         e.addr = dm_addr;
         e.data = dm_data;
         wr_log.push_back(e);
      end
      if (fence_done) done_pulses++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, 0);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic lv);
      cycle(0, 1, a, d, lv, '0, 0);
   endtask

   initial begin
      logic        ready_seen;
      logic [31:0] sa;
      logic [31:0] la;

      reset = 1; st_valid = 0; st_addr = '0; st_data = '0;
      ld_valid = 0; ld_addr = '0; fence_req = 0;
      mq.delete(); m_wr = 0; m_addr = '0; m_data = '0; m_mode = 0; m_done = 0;
      done_pulses = 0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_count", count, 0);
      check_eq("rst_wr_en", dm_wr_en, 0);
      check_eq("rst_fence_done", fence_done, 0);
      check_eq("rst_dm_addr", dm_addr, 0);
      check_eq("rst_dm_data", dm_data, 0);
      check_eq("rst_ld_hit", ld_hit, 0);
      check_eq("rst_st_ready", st_ready, 1);
      reset = 0;

      // Three stores with no loads drain back to back, in order.
      wr_log.delete();
      store(32'h00, 11, 0);
      store(32'h04, 22, 0);
      store(32'h08, 33, 0);
      idle(3);
      check_eq("t1_nwr", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         check_eq("t1_a0", wr_log[0].addr, 32'h00);
         check_eq("t1_d0", wr_log[0].data, 11);
         check_eq("t1_a1", wr_log[1].addr, 32'h04);
         check_eq("t1_d1", wr_log[1].data, 22);
         check_eq("t1_a2", wr_log[2].addr, 32'h08);
         check_eq("t1_d2", wr_log[2].data, 33);
      end
      check_eq("t1_count", count, 0);

      // Fill the buffer while loads hold the port, then release the port.
      wr_log.delete();
      for (int i = 0; i < 4; i++) store(32'h20 + 32'(4 * i), 32'(100 + i), 1);
      cycle(0, 1, 32'h3C, 999, 1, '0, 0);
      check_eq("t2_full_ready", last_ready, 0);
      check_eq("t2_count", count, 4);
      check_eq("t2_nwr_held", wr_log.size(), 0);
      idle(6);
      check_eq("t2_nwr", wr_log.size(), 4);
      if (wr_log.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check_eq("t2_addr", wr_log[i].addr, 32'h20 + 32'(4 * i));
            check_eq("t2_data", wr_log[i].data, 32'(100 + i));
         end
      end

      // The youngest store to a word wins, and a different word misses.
      store(32'h10, 5, 1);
      store(32'h10, 9, 1);
      cycle(0, 0, '0, '0, 1, 32'h10, 0);
      check_eq("t3_hit", last_hit, 1);
      check_eq("t3_data", last_ldata, 9);
      cycle(0, 0, '0, '0, 1, 32'h14, 0);
      check_eq("t3_miss_hit", last_hit, 0);
      check_eq("t3_miss_data", last_ldata, 0);
      idle(4);

      // An issued store that is not yet committed is still forwarded.
      store(32'h0C, 7, 0);
      idle(1);
      check_eq("t4_wr_en", dm_wr_en, 1);
      cycle(0, 0, '0, '0, 1, 32'h0C, 0);
      check_eq("t4_hit", last_hit, 1);
      check_eq("t4_data", last_ldata, 7);
      idle(2);

      // A fence drains the buffer even while loads are active.
      wr_log.delete();
      done_pulses = 0;
      store(32'h30, 1, 1);
      store(32'h34, 2, 1);
      cycle(0, 0, '0, '0, 1, '0, 1);
      ready_seen = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 32'h38, 77, 1, '0, 1);
         ready_seen |= last_ready;
      end
      cycle(0, 1, 32'h38, 77, 1, '0, 0);
      ready_seen |= last_ready;
      idle(3);
      check_eq("t5_ready_seen", ready_seen, 0);
      check_eq("t5_pulses", done_pulses, 1);
      check_eq("t5_nwr", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         check_eq("t5_a0", wr_log[0].addr, 32'h30);
         check_eq("t5_a1", wr_log[1].addr, 32'h34);
      end
      check_eq("t5_idle_ready", last_ready, 1);

      // Reset in the middle of operation discards the pending stores.
      wr_log.delete();
      store(32'h00, 41, 1);
      store(32'h04, 42, 1);
      store(32'h08, 43, 1);
      cycle(1, 0, '0, '0, 1, '0, 0);
      check_eq("t6_count", count, 0);
      check_eq("t6_wr_en", dm_wr_en, 0);
      idle(5);
      check_eq("t6_nwr", wr_log.size(), 0);

      // Random traffic against the model. Words 0..5 only, so that hits are frequent.
      for (int n = 0; n < 3000; n++) begin
         sa = ($urandom & ~32'h3C) | (32'($urandom_range(0, 5)) << 2);
         la = ($urandom & ~32'h3C) | (32'($urandom_range(0, 5)) << 2);
         cycle($urandom_range(0, 99) == 0, 1'($urandom), sa, $urandom,
               $urandom_range(0, 2) == 0, la, $urandom_range(0, 19) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Store buffer between the execute stage and the 16-word data memory. It queues word stores and drains them one per cycle into the memory write port (MemWr, word index addr[5:2], negedge write), yielding the port to loads. It also forwards buffered store data to loads that hit a pending address. A fence request drains the buffer completely and reports completion.

## Interface
- DEPTH, 4: number of store entries; must be a power of two, at least 2.
- DW, 32: data width.
- AW, 32: address width; only bits [5:2] are significant for matching and issue.
- clk  in  1  posedge clock for all state in this block.
- reset  in  1  reset, synchronous, active-high.
- st_valid  in  1  store request.
- st_addr  in  AW  store byte address.
- st_data  in  DW  store data.
- st_ready  out  1  store accepted this edge when st_valid && st_ready.
- ld_valid  in  1  load active on the memory port this cycle.
- ld_addr  in  AW  load byte address.
- ld_hit  out  1  combinational; a pending store matches ld_addr[5:2].
- ld_data  out  DW  combinational; forwarded data, 0 when !ld_hit.
- fence_req  in  1  level; request a full drain.
- fence_done  out  1  one-cycle pulse when the fence completes.
- dm_wr_en  out  1  registered; drives memory MemWr.
- dm_addr  out  AW  registered; address of the issued store.
- dm_data  out  DW  registered; data of the issued store.
- count  out  log2(DEPTH)+1  number of queued entries, excluding the entry being issued.

## Operation
- Circular FIFO with head pointer, tail pointer and count. Stored addresses are kept in full; matching uses bits [5:2] only.
- Enqueue: st_valid && st_ready writes {st_addr, st_data} at the tail. Tail and count advance.
- st_ready = (count != DEPTH) && state == IDLE.
  - A full buffer refuses a store even when a dequeue happens in the same cycle.
- Issue: at a posedge where count != 0 and the issue condition holds:
  - the head entry is loaded into dm_addr and dm_data, and dm_wr_en is set to 1;
  - the head pointer advances and count decrements.
  - Otherwise dm_wr_en is set to 0, and dm_addr/dm_data hold their previous values.
- Issue condition:
  - IDLE: !ld_valid (loads have priority on the port).
  - FENCE: always, regardless of ld_valid.
- Simultaneous enqueue and issue: count is unchanged, and both pointers move.
- Forwarding covers every queued entry plus the issued register when dm_wr_en == 1. The issued register is covered because the memory commits it only at the following negedge.
  - Priority is youngest first: queue entries from tail-1 back to head, then the issued register.
  - The st_data input is never bypassed in the same cycle.
- State machine:
  - IDLE -> FENCE when fence_req == 1.
  - FENCE -> DONE when count == 0 and no issue occurs at that edge.
  - DONE: fence_done = 1 for one cycle; then DONE -> IDLE unconditionally.
  - fence_req is ignored outside IDLE.
- Pointer wrap: modulo DEPTH. No overflow is possible because enqueue is gated by count.

## Timing
- Reset values:
  - head, tail and count are 0, and state is IDLE;
  - dm_wr_en, fence_done, dm_addr and dm_data are 0;
  - all queue entries are invalid, so ld_hit = 0.
- Reset asserted mid-operation discards all pending stores, including any issued store not yet committed. dm_wr_en is 0 from the following cycle.
- Latency from an accepted store to dm_wr_en is at least 1 cycle: a store accepted at edge N can be issued at edge N+1 at the earliest, and the memory commits it at the negedge inside cycle N+1.
- A store accepted at edge N is forwardable from cycle N+1 (i.e. after edge N).
- Each cycle with ld_valid == 1 in IDLE delays draining by exactly one cycle.
- Fence:
  - with k queued entries, DONE is entered at edge k+1 after the FENCE entry edge;
  - with an empty buffer, DONE is entered at the first edge after FENCE is entered;
  - st_ready stays 0 from FENCE entry until the cycle after DONE.

## Test plan
- Reset, then 3 stores with no loads: addresses 0x00, 0x04, 0x08 and data 11, 22, 33 -> dm_wr_en high for 3 consecutive cycles with those pairs in order; count returns to 0.
- Fill 4 entries while ld_valid is held at 1 -> st_ready = 0 at count = 4, no dm_wr_en. Release ld_valid -> 4 drains in FIFO order.
- Stores to 0x10 with data 5, then 0x10 with data 9 queued; load at 0x10 -> ld_hit = 1, ld_data = 9. Load at 0x14 -> ld_hit = 0, ld_data = 0.
- Store to 0x0C with data 7 issued, so dm_wr_en = 1; load at 0x0C in the same cycle -> ld_hit = 1, ld_data = 7.
- 2 stores queued, fence_req held with ld_valid = 1 -> both drain despite the load, fence_done pulses once, st_ready is 0 throughout, then IDLE.
- Reset asserted with 3 entries pending -> count = 0, dm_wr_en = 0 next cycle, and none of the pending stores is ever issued.
